pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions:
- load-use hazards;
- taken branches resolved in MEM;
- multi-cycle data-memory accesses, via a req/ready handshake with a timeout watchdog.

---
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard status from the pipeline stages and the
// stall/flush controls returned to them.
//   master : pipeline side (drives stage status, receives controls)
//   slave  : hazard controller (receives status, drives controls)
interface pipe_hazard_ctrl_if;
  // ID / EX register-use information
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  // MEM stage branch outcome and data-memory handshake
  logic       mem_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  // Pipeline controls
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       stall;
  logic       mem_err;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, stall, mem_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, stall, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage RISC-V pipeline.
// Resolves data-memory wait states (with a timeout watchdog), taken
// branches in MEM and load-use hazards, in that priority order.
// Controls are Mealy outputs; only the wait counter, state and the sticky
// mem_err flag are registered.
// Optional feature: define PIPE_HAZARD_PERF_CNT_EN to add saturating
// stall_cycles / flush_events counters as extra output ports.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_events
`endif
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic             load_use;
  logic             mem_miss;
  logic             wait_timeout;
  logic             wait_release;
  // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [4:0]       en_vec;
  // {if_id, id_ex, ex_mem}
  logic [2:0]       flush_vec;

  // A load in EX feeding a register read in ID; x0 is never a real dependency.
  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
  assign mem_miss     = hz.mem_req && !hz.mem_ready;
  assign wait_timeout = (wait_cnt_q >= CNT_MAX);
  // A timeout releases the pipeline exactly like a late ready does.
  assign wait_release = hz.mem_ready || wait_timeout;

  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next state: enter the wait on a miss, leave on ready or timeout
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_miss) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_timeout) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output decode: freeze on memory wait, flush on branch, bubble on load-use
  always_comb begin
    en_vec    = 5'b00000;
    flush_vec = 3'b000;
    if (reset) begin
      case (state_q)
        RUN: begin
          if (!mem_miss) begin
            en_vec = 5'b11111;
            if (hz.mem_branch_taken) begin
              flush_vec = 3'b111;
            end else if (load_use) begin
              // Hold PC and IF/ID, bubble into ID/EX; the load moves on.
              en_vec    = 5'b00111;
              flush_vec = 3'b010;
            end
          end
        end
        MEM_WAIT: begin
          if (wait_release) begin
            en_vec = 5'b11111;
            if (hz.mem_branch_taken) begin
              flush_vec = 3'b111;
            end
          end
        end
        default: begin
          en_vec    = 5'b00000;
          flush_vec = 3'b000;
        end
      endcase
    end
  end

  assign hz.pc_en        = en_vec[4];
  assign hz.if_id_en     = en_vec[3];
  assign hz.id_ex_en     = en_vec[2];
  assign hz.ex_mem_en    = en_vec[1];
  assign hz.mem_wb_en    = en_vec[0];
  assign hz.if_id_flush  = flush_vec[2];
  assign hz.id_ex_flush  = flush_vec[1];
  assign hz.ex_mem_flush = flush_vec[0];
  assign hz.stall        = !en_vec[4];
  assign hz.mem_err      = mem_err_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  // Saturating event counters
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!en_vec[4] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (flush_vec[0] && (flush_events_q != 32'hFFFF_FFFF)) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven directed vectors, hand-written
// multi-cycle sequences (asynchronous abort, timeout with branch, optional
// perf counters) and a randomized run checked against a reference model.
module tb_pipe_hazard_ctrl;

  localparam int MAXW = 4;

  // Expected control word: {pc, if_id, id_ex, ex_mem, mem_wb en,
  //                         if_id, id_ex, ex_mem flush, stall}
  localparam logic [8:0] O_RST = 9'b00000_000_1;
  localparam logic [8:0] O_FRZ = 9'b00000_000_1;
  localparam logic [8:0] O_RUN = 9'b11111_000_0;
  localparam logic [8:0] O_LU  = 9'b00111_010_1;
  localparam logic [8:0] O_BR  = 9'b11111_111_0;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       exr;
    logic [4:0] exrd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [8:0] exp_ctrl;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz ();

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (hz)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  int vec_count = 0;
  int miscompares = 0;
  int vec_id = 0;

  // Reference model state: number of wait cycles spent so far (0 = none).
  int m_wait = 0;
  bit m_err  = 1'b0;

  function automatic vec_t mk(input logic rst_n, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic exr,
                              input logic [4:0] exrd, input logic br,
                              input logic req, input logic rdy,
                              input logic [8:0] exp_ctrl, input logic exp_err);
    vec_t v;
    v.rst_n = rst_n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.exr = exr; v.exrd = exrd; v.br = br; v.req = req; v.rdy = rdy;
    v.exp_ctrl = exp_ctrl; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic logic [8:0] dut_ctrl();
    return {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
            hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.stall};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset               = v.rst_n;
    hz.id_rs1           = v.rs1;
    hz.id_rs2           = v.rs2;
    hz.id_use_rs1       = v.u1;
    hz.id_use_rs2       = v.u2;
    hz.ex_mem_read      = v.exr;
    hz.ex_rd            = v.exrd;
    hz.mem_branch_taken = v.br;
    hz.mem_req          = v.req;
    hz.mem_ready        = v.rdy;
  endtask

  // One transaction: drive at edge+1, check mid-cycle, advance a clock.
  task automatic run_vec(input vec_t v, input string tag);
    apply(v);
    #4;
    check($sformatf("%s_ctrl[%0d]", tag, vec_id), {23'd0, dut_ctrl()}, {23'd0, v.exp_ctrl});
    check($sformatf("%s_err[%0d]", tag, vec_id), {31'd0, hz.mem_err}, {31'd0, v.exp_err});
    $display("vec %0d %s rst_n=%b br=%b req=%b rdy=%b ldu_in=%b/%0d/%0d ctrl=%b err=%b",
             vec_id, tag, v.rst_n, v.br, v.req, v.rdy, v.exr, v.exrd, v.rs1,
             dut_ctrl(), hz.mem_err);
    vec_id++;
    @(posedge clk);
    #1;
  endtask

  // Expected controls straight from the priority rules.
  function automatic logic [8:0] model_ctrl(input vec_t v);
    bit hazard;
    hazard = v.exr && (v.exrd != 0) &&
             ((v.u1 && (v.rs1 == v.exrd)) || (v.u2 && (v.rs2 == v.exrd)));
    if (!v.rst_n) return O_RST;
    if (m_wait != 0) begin
      if (!(v.rdy || (m_wait >= MAXW))) return O_FRZ;
      return v.br ? O_BR : O_RUN;
    end
    if (v.req && !v.rdy) return O_FRZ;
    if (v.br) return O_BR;
    if (hazard) return O_LU;
    return O_RUN;
  endfunction

  task automatic model_step(input vec_t v);
    if (!v.rst_n) begin
      m_wait = 0;
      m_err  = 1'b0;
    end else if (m_wait != 0) begin
      if (v.rdy) begin
        m_wait = 0;
      end else if (m_wait >= MAXW) begin
        m_wait = 0;
        m_err  = 1'b1;
      end else begin
        m_wait = m_wait + 1;
      end
    end else if (v.req && !v.rdy) begin
      m_wait = 1;
    end
  endtask

  vec_t tbl [27];

  initial begin
    vec_t v;
    vec_t idle;

    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0);
    //          rst rs1 rs2 u1 u2 exr rd br req rdy  ctrl  err
    tbl[0]  = mk(0, 5, 5, 1, 1, 1, 5, 1, 1, 0, O_RST, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0);
    tbl[3]  = mk(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, O_LU,  0);
    tbl[4]  = mk(1, 5, 0, 1, 0, 0, 5, 0, 0, 0, O_RUN, 0);
    tbl[5]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, O_RUN, 0);
    tbl[6]  = mk(1, 3, 7, 0, 1, 1, 7, 0, 0, 0, O_LU,  0);
    tbl[7]  = mk(1, 3, 7, 1, 0, 1, 7, 0, 0, 0, O_RUN, 0);
    tbl[8]  = mk(1, 5, 0, 1, 0, 1, 5, 1, 0, 0, O_BR,  0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN, 0);
    tbl[10] = mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, O_FRZ, 0);
    tbl[11] = mk(1, 5, 0, 1, 0, 1, 5, 0, 1, 0, O_FRZ, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0);
    tbl[13] = mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 1, O_BR,  0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_RUN, 0);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 1);
    tbl[21] = mk(1, 9, 0, 1, 0, 1, 9, 0, 0, 0, O_LU,  1);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0);
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0);
    tbl[25] = mk(1, 5, 0, 1, 0, 1, 5, 0, 1, 1, O_RUN, 0);
    tbl[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0);

    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0));
    @(posedge clk);
    #1;

    // Directed table
    foreach (tbl[i]) run_vec(tbl[i], "tbl");

    // Reset asserted in the middle of a wait aborts it at once.
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ, 0);
    run_vec(v, "abort_enter");
    apply(v);
    #2;
    reset = 1'b0;
    #1;
    check("abort_async_ctrl", {23'd0, dut_ctrl()}, {23'd0, O_RST});
    check("abort_async_err", {31'd0, hz.mem_err}, 32'd0);
    $display("vec %0d abort_async ctrl=%b err=%b", vec_id, dut_ctrl(), hz.mem_err);
    vec_id++;
    @(posedge clk);
    #1;
    run_vec(idle, "abort_after");

    // Timeout with a taken branch on the release cycle, then sticky error.
    for (int k = 0; k < MAXW + 1; k++) begin
      v = mk(1, 0, 0, 0, 0, 0, 0, (k == MAXW), 1, 0, (k < MAXW) ? O_FRZ : O_BR, 0);
      run_vec(v, "tmo");
    end
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 1);
    run_vec(v, "tmo_sticky");
    run_vec(v, "tmo_sticky");

`ifdef PIPE_HAZARD_PERF_CNT_EN
    // Two load-use stalls and one branch after a fresh reset.
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0), "perf");
    run_vec(idle, "perf");
    run_vec(mk(1, 4, 0, 1, 0, 1, 4, 0, 0, 0, O_LU, 0), "perf");
    run_vec(idle, "perf");
    run_vec(mk(1, 0, 6, 0, 1, 1, 6, 0, 0, 0, O_LU, 0), "perf");
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR, 0), "perf");
    apply(idle);
    #4;
    check("perf_stall_cycles", stall_cycles, 32'd2);
    check("perf_flush_events", flush_events, 32'd1);
    $display("vec %0d perf stall_cycles=%0d flush_events=%0d", vec_id, stall_cycles, flush_events);
    vec_id++;
    @(posedge clk);
    #1;
`endif

    // Randomized run against the reference model, starting from reset.
    m_wait = 0;
    m_err  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      v.rst_n = (n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom);
      v.u2    = 1'($urandom);
      v.exr   = 1'($urandom);
      v.exrd  = 5'($urandom_range(0, 3));
      v.br    = ($urandom_range(0, 5) == 0);
      v.req   = ($urandom_range(0, 2) == 0);
      v.rdy   = ($urandom_range(0, 9) < 3);
      v.exp_ctrl = model_ctrl(v);
      v.exp_err  = v.rst_n ? m_err : 1'b0;
      run_vec(v, "rnd");
      model_step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  // Watchdog: the sequence is fixed-length, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
